// File: rtl/div_pkg.sv
// Shared encodings and helpers for the sequential integer divider.
package div_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int CNT_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic is_signed_op(op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem_op(op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    // Low XLEN bits of the XLEN+1-bit difference are exact whenever it is taken.
    diff    = shifted[XLEN-1:0] - divisor;
    if (shifted >= {1'b0, divisor}) begin
      rem_next = diff;
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned divider: one quotient bit per clock, fixed
// latency, busy_o stalls the pipeline and valid_o pulses with the result.
module seq_divider
  import div_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  state_e           state;
  op_e              op_q;
  logic [XLEN-1:0]  rem_q, quo_q, dvsr_q;
  logic [XLEN-1:0]  rem_nx, quo_nx;
  logic             sign_q, sign_r, div0_q, last_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept, in_signed;
  op_e              op_in;
  logic [XLEN-1:0]  dividend_mag, divisor_mag;
  logic [XLEN-1:0]  quotient, remainder, final_result;

  assign op_in     = op_e'(op_i);
  assign in_signed = is_signed_op(op_in);
  assign accept    = (state == IDLE) && start_i && !flush_i;

  assign dividend_mag = (in_signed && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
  assign divisor_mag  = (in_signed && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvsr_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  // A zero divisor leaves |dividend| in the remainder, so re-signing it
  // already reproduces the original dividend; only the quotient is forced.
  assign quotient     = div0_q ? '1 : (sign_q ? -quo_q : quo_q);
  assign remainder    = sign_r ? -rem_q : rem_q;
  assign final_result = is_rem_op(op_q) ? remainder : quotient;

  // NOTE: operand/partial-result registers carry no reset; they are always
  // loaded on accept before being read, so only control state is reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q   <= op_in;
      quo_q  <= dividend_mag;
      dvsr_q <= divisor_mag;
      rem_q  <= '0;
      sign_q <= in_signed && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
      sign_r <= in_signed && dividend_i[XLEN-1];
      div0_q <= (divisor_i == '0);
    end else if (state == RUN && !last_q) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_o <= 1'b0;
          if (accept) begin
            state  <= RUN;
            busy_o <= 1'b1;
            cnt_q  <= '0;
            last_q <= 1'b0;
          end
        end
        RUN: begin
          if (flush_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (last_q) begin
            // All XLEN steps are done; publish the re-signed result.
            state    <= DONE;
            busy_o   <= 1'b0;
            valid_o  <= 1'b1;
            result_o <= final_result;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN - 1)) last_q <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          valid_o <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy_o  <= 1'b0;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed and random operations checked
// against an arithmetic reference, plus handshake, flush and reset scenarios.
module tb_seq_divider;
  import div_pkg::*;

  localparam int LAT  = 34;   // negedge index of valid_o, counting the accept edge as 0
  localparam int BUSY = 33;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, valid;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;

  seq_divider dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .op_i       (op),
    .dividend_i (a),
    .divisor_i  (b),
    .flush_i    (flush),
    .busy_o     (busy),
    .valid_o    (valid),
    .result_o   (result)
  );

  always #5 clk = ~clk;

  // Reference: 64-bit signed arithmetic truncates toward zero and makes the
  // -2^31 / -1 case fall out naturally.
  function automatic logic [31:0] ref_result(op_e o, logic [31:0] x, logic [31:0] y);
    longint sx, sy;
    if (y == 32'd0) return (o == DIV || o == DIVU) ? 32'hFFFF_FFFF : x;
    if (o == DIV || o == REM) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return (o == DIV) ? 32'(sx / sy) : 32'(sx % sy);
    end
    return (o == DIVU) ? x / y : x % y;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issues one operation and watches until valid_o (bounded); returns the
  // observed result, negedge index of valid_o, busy count and valid_o one cycle later.
  task automatic run_op(input op_e o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat, output int bcnt,
                        output logic after);
    res = '0; lat = -1; bcnt = 0; after = 1'bx;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0; a = $urandom; b = $urandom;
      end
      if (busy) bcnt++;
      if (valid) begin
        lat = n; res = result;
        break;
      end
    end
    @(negedge clk);
    after = valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'd0) begin
      miscompares++;
      $display("FAIL reset: busy=%b valid=%b result=%h, want 0 0 00000000", busy, valid, result);
    end
    rst = 1'b0;
  endtask

  task automatic do_dir(input string name, input op_e o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp);
    logic [31:0] res; int lat, bcnt; logic after;
    run_op(o, x, y, res, lat, bcnt, after);
    vectors++;
    if (res !== exp) begin
      miscompares++;
      $display("FAIL %s result: got %h, want %h", name, res, exp);
    end
    vectors++;
    if (lat !== LAT || bcnt !== BUSY || after !== 1'b0) begin
      miscompares++;
      $display("FAIL %s timing: valid at %0d busy %0d after %b, want %0d %0d 0",
               name, lat, bcnt, after, LAT, BUSY);
    end
  endtask

  task automatic test_directed();
    do_dir("divu_100_7",  DIVU, 32'd100, 32'd7, 32'd14);
    do_dir("remu_100_7",  REMU, 32'd100, 32'd7, 32'd2);
    do_dir("div_m7_2",    DIV,  -32'sd7, 32'd2, 32'hFFFF_FFFD);
    do_dir("rem_m7_2",    REM,  -32'sd7, 32'd2, 32'hFFFF_FFFF);
    do_dir("div_7_m2",    DIV,  32'd7, -32'sd2, 32'hFFFF_FFFD);
    do_dir("rem_7_m2",    REM,  32'd7, -32'sd2, 32'd1);
    do_dir("div_5_0",     DIV,  32'd5, 32'd0, 32'hFFFF_FFFF);
    do_dir("rem_5_0",     REM,  32'd5, 32'd0, 32'd5);
    do_dir("divu_max_0",  DIVU, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF);
    do_dir("div_ovf",     DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_dir("rem_ovf",     REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    do_dir("rem_m9_0",    REM,  -32'sd9, 32'd0, 32'hFFFF_FFF7);
  endtask

  task automatic test_random();
    op_e o; logic [31:0] x, y, res, exp; int lat, bcnt; logic after;
    for (int i = 0; i < 50; i++) begin
      o = op_e'($urandom_range(0, 3));
      x = pick_operand();
      y = pick_operand();
      exp = ref_result(o, x, y);
      run_op(o, x, y, res, lat, bcnt, after);
      vectors++;
      if (res !== exp || lat !== LAT) begin
        miscompares++;
        $display("FAIL random[%0d] op=%0d %h/%h: got %h at %0d, want %h at %0d",
                 i, o, x, y, res, lat, exp, LAT);
      end
    end
  endtask

  // start_i held for 40 cycles with fresh operands every cycle: the DONE cycle
  // ignores it, so the second accept lands on the first IDLE edge (n=35).
  task automatic test_back_to_back();
    op_e ops[80]; logic [31:0] xs[80], ys[80], res[2]; int at[2]; int nvalid;
    nvalid = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (n > 0 && valid) begin
        if (nvalid < 2) begin res[nvalid] = result; at[nvalid] = n; end
        nvalid++;
      end
      ops[n] = op_e'($urandom_range(0, 3));
      xs[n] = pick_operand();
      ys[n] = pick_operand();
      start = (n < 40); op = ops[n]; a = xs[n]; b = ys[n];
    end
    start = 1'b0;
    vectors++;
    if (nvalid !== 2) begin
      miscompares++;
      $display("FAIL b2b pulses: got %0d, want 2", nvalid);
    end else begin
      vectors++;
      if (at[0] !== LAT || res[0] !== ref_result(ops[0], xs[0], ys[0])) begin
        miscompares++;
        $display("FAIL b2b first: got %h at %0d, want %h at %0d",
                 res[0], at[0], ref_result(ops[0], xs[0], ys[0]), LAT);
      end
      vectors++;
      if (at[1] !== 35 + LAT || res[1] !== ref_result(ops[35], xs[35], ys[35])) begin
        miscompares++;
        $display("FAIL b2b second: got %h at %0d, want %h at %0d",
                 res[1], at[1], ref_result(ops[35], xs[35], ys[35]), 35 + LAT);
      end
    end
  endtask

  task automatic test_done_start();
    int nvalid, nbusy;
    nvalid = 0; nbusy = 0;
    @(negedge clk);
    start = 1'b1; op = DIVU; a = 32'd50; b = 32'd5;
    for (int n = 1; n < 80; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid) nvalid++;
      if (n > LAT && busy) nbusy++;
      if (n == LAT) begin
        start = 1'b1; op = DIV; a = 32'd9; b = 32'd3;
      end
    end
    vectors++;
    if (nvalid !== 1 || nbusy !== 0) begin
      miscompares++;
      $display("FAIL done_start: pulses %0d busy-after %0d, want 1 0", nvalid, nbusy);
    end
  endtask

  task automatic test_flush();
    logic [31:0] res; int lat, bcnt, nvalid, nbusy; logic after;
    run_op(DIVU, 32'd100, 32'd7, res, lat, bcnt, after);
    vectors++;
    if (res !== 32'd14) begin
      miscompares++;
      $display("FAIL flush_prep: got %h, want %h", res, 32'd14);
    end
    @(negedge clk);
    start = 1'b1; op = DIVU; a = 32'd1000; b = 32'd3;
    nvalid = 0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 10) flush = 1'b1;
      if (n == 11) begin
        flush = 1'b0;
        vectors++;
        if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'd14) begin
          miscompares++;
          $display("FAIL flush_run: busy=%b valid=%b result=%h, want 0 0 %h",
                   busy, valid, result, 32'd14);
        end
      end
      if (valid) nvalid++;
    end
    vectors++;
    if (nvalid !== 0) begin
      miscompares++;
      $display("FAIL flush_novalid: got %0d pulses, want 0", nvalid);
    end
    // start and flush together in IDLE must not accept
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = DIV; a = 32'd77; b = 32'd7;
    nvalid = 0; nbusy = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      if (busy) nbusy++;
      if (valid) nvalid++;
    end
    vectors++;
    if (nvalid !== 0 || nbusy !== 0) begin
      miscompares++;
      $display("FAIL flush_start_idle: pulses %0d busy %0d, want 0 0", nvalid, nbusy);
    end
    do_dir("after_flush", DIV, 32'd1000, -32'sd3, 32'hFFFF_FEB3);
  endtask

  task automatic test_reset_mid();
    int nvalid;
    nvalid = 0;
    @(negedge clk);
    start = 1'b1; op = REMU; a = 32'd12345; b = 32'd100;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 20) rst = 1'b1;
      if (n == 21) begin
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'd0) begin
          miscompares++;
          $display("FAIL reset_mid: busy=%b valid=%b result=%h, want 0 0 00000000",
                   busy, valid, result);
        end
      end
      if (valid) nvalid++;
    end
    vectors++;
    if (nvalid !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_novalid: got %0d pulses, want 0", nvalid);
    end
    do_dir("div_100_m7", DIV, 32'd100, -32'sd7, 32'hFFFF_FFF2);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_done_start();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
